// File: rtl/count_monitor.sv
// ============================================================================
//  Module      : count_monitor
//  Description : Samples the asynchronous outputs of a 5-bit ripple
//                down-counter, filters them until they are stable, and then
//                publishes the count. Flags 0->31 underflows and keeps a
//                saturating underflow count.
//                Optional feature macro: COUNT_MONITOR_ERR_EN adds a sticky
//                'err' output that flags any published step that is not a
//                single down-count.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module count_monitor #(
  parameter int STABLE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       clear,
  input  logic [4:0] cnt_in,
  input  logic       enable,
  output logic [4:0] value,
  output logic       valid,
  output logic       zero,
  output logic       wrap,
  output logic [7:0] wrap_count
`ifdef COUNT_MONITOR_ERR_EN
  ,
  output logic       err
`endif
);

  // run saturates at the full stable length; publish fires one sample earlier
  // because the current edge supplies the final matching sample.
  localparam logic [3:0] c_run_max = 4'(STABLE_CYCLES);
  localparam logic [3:0] c_pub_run = 4'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_INIT   = 2'd0,
    S_SETTLE = 2'd1,
    S_STABLE = 2'd2
  } state_t;

  logic [4:0] r_sync1;
  logic [4:0] r_sync2;
  logic [4:0] r_cand;
  logic [3:0] r_run;
  state_t     r_state;
  logic [4:0] r_value;
  logic       r_valid;
  logic       r_zero;
  logic       r_wrap;
  logic [7:0] r_wrap_count;

  logic       w_same;
  logic       w_publish;
  logic       w_underflow;

  assign w_same      = (r_sync2 == r_cand);
  // A repeat of the current value is not re-published, except for the very
  // first publish after clear when nothing is valid yet.
  assign w_publish   = enable && w_same && (r_run == c_pub_run) &&
                       ((r_cand != r_value) || (r_state == S_INIT));
  assign w_underflow = w_publish && (r_state != S_INIT) &&
                       (r_value == 5'd0) && (r_cand == 5'd31);

  // Two-flop synchronizer for the asynchronous counter bits.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_sync1 <= 5'd0;
      r_sync2 <= 5'd0;
    end else begin
      r_sync1 <= cnt_in;
      r_sync2 <= r_sync1;
    end
  end

  // Stability filter: track the candidate and count identical samples.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_cand <= 5'd0;
      r_run  <= 4'd0;
    end else begin
      if (!w_same) begin
        r_cand <= r_sync2;
      end
      if (!enable) begin
        r_run <= 4'd0;
      end else if (!w_same) begin
        r_run <= 4'd1;
      end else if (r_run != c_run_max) begin
        r_run <= r_run + 4'd1;
      end
    end
  end

  // Publication FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_state      <= S_INIT;
      r_value      <= 5'd0;
      r_valid      <= 1'b0;
      r_zero       <= 1'b0;
      r_wrap       <= 1'b0;
      r_wrap_count <= 8'd0;
    end else begin
      r_valid <= w_publish;
      r_wrap  <= w_underflow;
      if (w_publish) begin
        r_value <= r_cand;
        r_zero  <= (r_cand == 5'd0);
      end
      if (w_underflow && (r_wrap_count != 8'hFF)) begin
        r_wrap_count <= r_wrap_count + 8'd1;
      end
      case (r_state)
        S_INIT: begin
          if (w_publish) begin
            r_state <= S_STABLE;
          end
        end
        S_STABLE: begin
          if (!w_publish && (r_sync2 != r_value)) begin
            r_state <= S_SETTLE;
          end
        end
        S_SETTLE: begin
          if (w_publish || (r_sync2 == r_value)) begin
            r_state <= S_STABLE;
          end
        end
        default: begin
          r_state <= S_INIT;
        end
      endcase
    end
  end

`ifdef COUNT_MONITOR_ERR_EN
  logic r_err;
  logic w_bad_step;

  // A legitimate publish after the first one is exactly one count below the
  // previous value, modulo 32.
  assign w_bad_step = w_publish && (r_state != S_INIT) &&
                      (r_cand != (r_value - 5'd1));

  // Sticky sequence-error flag, cleared only by clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      r_err <= 1'b0;
    end else if (w_bad_step) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`endif

  assign value      = r_value;
  assign valid      = r_valid;
  assign zero       = r_zero;
  assign wrap       = r_wrap;
  assign wrap_count = r_wrap_count;

endmodule

`default_nettype wire

// File: tb/tb_count_monitor.sv
// ============================================================================
//  Module      : tb_count_monitor
//  Description : Self-checking bench for count_monitor. A behavioural model
//                tracks the synchronized sample stream, the length of the
//                current streak of identical enabled samples and whether
//                anything has been published, and predicts every output on
//                every clock. Directed sequences plus randomized counting.
//                Honours COUNT_MONITOR_ERR_EN when defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_count_monitor;

  localparam int STABLE_CYCLES = 2;

  logic       clk = 1'b0;
  logic       clear;
  logic       enable;
  logic [4:0] cnt_in;
  logic [4:0] value;
  logic       valid;
  logic       zero;
  logic       wrap;
  logic [7:0] wrap_count;
`ifdef COUNT_MONITOR_ERR_EN
  logic       err;
`endif

  count_monitor #(.STABLE_CYCLES(STABLE_CYCLES)) dut (
    .clk        (clk),
    .clear      (clear),
    .cnt_in     (cnt_in),
    .enable     (enable),
    .value      (value),
    .valid      (valid),
    .zero       (zero),
    .wrap       (wrap),
    .wrap_count (wrap_count)
`ifdef COUNT_MONITOR_ERR_EN
    ,
    .err        (err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int n_valid = 0;
  int n_wrap  = 0;

  // Reference model state
  int m_hist[2];      // [0] = newest sample, [1] = sample seen by the filter
  int m_cand;
  int m_streak;       // unbounded count of consecutive matching enabled samples
  int m_value;
  int m_wc;
  bit m_pub;          // something has been published since clear
  bit m_valid;
  bit m_wrap;
  bit m_err;

  task automatic check(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    if (obs !== 32'(exp)) begin
      errors++;
      $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance the model by one rising edge using the inputs present at the edge.
  task automatic model_edge();
    bit fire;
    if (clear) begin
      m_hist[0] = 0; m_hist[1] = 0;
      m_cand = 0; m_streak = 0; m_value = 0; m_wc = 0;
      m_pub = 0; m_valid = 0; m_wrap = 0; m_err = 0;
    end else begin
      fire = enable && (m_hist[1] == m_cand) && (m_streak == STABLE_CYCLES - 1) &&
             ((m_cand != m_value) || !m_pub);
      m_valid = fire;
      m_wrap  = fire && m_pub && (m_value == 0) && (m_cand == 31);
      if (m_wrap && m_wc < 255) m_wc++;
      if (fire && m_pub && (((m_value - m_cand + 32) % 32) != 1)) m_err = 1;
      if (fire) begin
        m_value = m_cand;
        m_pub   = 1;
      end
      if (!enable)                 m_streak = 0;
      else if (m_hist[1] != m_cand) m_streak = 1;
      else                          m_streak++;
      m_cand    = m_hist[1];
      m_hist[1] = m_hist[0];
      m_hist[0] = int'(cnt_in);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("value", 32'(value), m_value);
    check("valid", 32'(valid), int'(m_valid));
    check("zero", 32'(zero), int'(m_pub && (m_value == 0)));
    check("wrap", 32'(wrap), int'(m_wrap));
    check("wrap_count", 32'(wrap_count), m_wc);
`ifdef COUNT_MONITOR_ERR_EN
    check("err", 32'(err), int'(m_err));
`endif
    if (valid === 1'b1) n_valid++;
    if (wrap === 1'b1)  n_wrap++;
  endtask

  task automatic hold(input int v, input int n);
    cnt_in = 5'(v);
    repeat (n) tick();
  endtask

  initial begin
    clear  = 1'b1;
    enable = 1'b1;
    cnt_in = 5'd7;

    // Reset then a steady 7 with enable held
    tick();
    check("reset_value", 32'(value), 0);
    check("reset_wc", 32'(wrap_count), 0);
    tick();
    clear = 1'b0;
    repeat (3) tick();
    tick();
    check("first_pub_valid", 32'(valid), 1);
    check("first_pub_value", 32'(value), 7);
    check("first_pub_zero", 32'(zero), 0);
    check("first_pub_wrap", 32'(wrap), 0);
    hold(7, 4);

    // Down-count through the underflow
    n_valid = 0; n_wrap = 0;
    hold(2, 6);
    hold(1, 6);
    hold(0, 6);
    check("zero_at_0", 32'(zero), 1);
    hold(31, 6);
    check("down_valids", 32'(n_valid), 4);
    check("down_wraps", 32'(n_wrap), 1);
    check("down_wc", 32'(wrap_count), 1);
    check("zero_at_31", 32'(zero), 0);

    // Short glitch must not be published
    hold(10, 6);
    n_valid = 0;
    hold(13, 1);
    hold(10, 6);
    check("glitch_valids", 32'(n_valid), 0);
    check("glitch_value", 32'(value), 10);

    // Enable gating, then clear mid-settle
    hold(20, 6);
    enable = 1'b0;
    n_valid = 0;
    hold(19, 6);
    check("disabled_value", 32'(value), 20);
    check("disabled_valids", 32'(n_valid), 0);
    enable = 1'b1;
    tick();
    tick();
    check("enable_value", 32'(value), 19);
    check("enable_valid", 32'(valid), 1);
    hold(5, 3);
    clear = 1'b1;
    tick();
    check("clear_value", 32'(value), 0);
    check("clear_valid", 32'(valid), 0);
    check("clear_zero", 32'(zero), 0);
    check("clear_wc", 32'(wrap_count), 0);
    clear = 1'b0;

    // Underflow count saturation
    n_wrap = 0;
    for (int i = 0; i < 300; i++) begin
      hold(0, 4);
      hold(31, 4);
    end
    check("sat_wc", 32'(wrap_count), 255);
    check("sat_wraps", 32'(n_wrap), 300);

`ifdef COUNT_MONITOR_ERR_EN
    // Bad step 9 -> 6 sets err; good step 9 -> 8 leaves it clear
    enable = 1'b0;
    clear  = 1'b1;
    cnt_in = 5'd9;
    tick();
    clear = 1'b0;
    hold(9, 4);
    enable = 1'b1;
    hold(9, 4);
    hold(6, 6);
    check("err_bad_step", 32'(err), 1);
    hold(5, 6);
    check("err_sticky", 32'(err), 1);
    enable = 1'b0;
    clear  = 1'b1;
    tick();
    clear = 1'b0;
    hold(9, 4);
    enable = 1'b1;
    hold(9, 4);
    hold(8, 6);
    check("err_good_value", 32'(value), 8);
    check("err_good_step", 32'(err), 0);
`endif

    // Randomized counting with glitches, enable toggles and occasional clear
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0) enable = ~enable;
      if ($urandom_range(0, 3) == 0) cnt_in = 5'($urandom_range(0, 31));
      else                           cnt_in = cnt_in - 5'd1;
      if ($urandom_range(0, 59) == 0) begin
        clear = 1'b1;
        tick();
        clear = 1'b0;
      end
      repeat ($urandom_range(1, 7)) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 The block SHALL have parameter STABLE_CYCLES, default 2, giving the consecutive identical synchronized samples required to publish a count (legal range 2..15).
REQ-002 Port clk SHALL be an input, 1 bit, the single block clock; all state updates on its rising edge.
REQ-003 Port clear SHALL be an input, 1 bit, the synchronous active-high reset.
REQ-004 Port cnt_in SHALL be an input, 5 bits, the raw ripple down-counter outputs {a,b,c,d,e}, asynchronous to clk.
REQ-005 Port enable SHALL be an input, 1 bit, the publication enable.
REQ-006 Port value SHALL be an output, 5 bits, the last published stable count.
REQ-007 Port valid SHALL be an output, 1 bit, a one-cycle pulse marking a new publication.
REQ-008 Port zero SHALL be an output, 1 bit, a level that is high when the block has published and value==0.
REQ-009 Port wrap SHALL be an output, 1 bit, a one-cycle pulse marking a 0->31 underflow.
REQ-010 Port wrap_count SHALL be an output, 8 bits, the underflow count, saturating.

Function
REQ-011 cnt_in SHALL pass through a two-flop synchronizer (sync1, sync2) per bit, running whenever clear is low, independent of enable.
REQ-012 The filter SHALL hold cand (5 bits) and run (4 bits): if sync2!=cand then cand<=sync2, run<=1; else run<=run+1, saturating at STABLE_CYCLES.
REQ-013 When enable=1, sync2==cand and run==STABLE_CYCLES-1, the block SHALL publish in that edge: value<=cand, valid<=1 for exactly one cycle, provided cand differs from value or state is S_INIT.
REQ-014 Latency SHALL be STABLE_CYCLES+2 rising edges: for cnt_in stable across sampling edges k..k+STABLE_CYCLES+1, value and valid update after edge k+STABLE_CYCLES+1.
REQ-015 The FSM SHALL have three states. S_INIT: nothing published yet. S_SETTLE: cand!=value. S_STABLE: cand==value.
REQ-016 The FSM SHALL go S_INIT->S_STABLE on the first publish, S_STABLE->S_SETTLE when sync2 differs from value, and S_SETTLE->S_STABLE on publish or when sync2 returns to value (no valid pulse in that case).
REQ-017 A publish with old value==0, new value==31 and state!=S_INIT SHALL pulse wrap together with valid and increment wrap_count, which SHALL hold at 255 (no wrap to 0).
REQ-018 Any other transition, including 31->0 and a first publish of 31, SHALL NOT pulse wrap.
REQ-019 With enable=0, run SHALL be forced to 0, cand SHALL keep tracking sync2, and no valid or wrap SHALL occur; value and wrap_count SHALL hold.
REQ-020 After enable rises, a full STABLE_CYCLES run SHALL be required before any publish.
REQ-021 An input glitch shorter than STABLE_CYCLES synchronized cycles SHALL never be published.
REQ-022 zero SHALL be registered from value, with no extra cycle relative to value.

Reset
REQ-023 clear=1 at a rising edge SHALL set the following: sync1=sync2=cand=0, run=0, state=S_INIT, value=0, valid=0, wrap=0, zero=0, wrap_count=0, err=0.
REQ-024 clear SHALL override enable and any publish in the same edge, including mid-settle.
REQ-025 After clear, the first publish SHALL be treated as an S_INIT publish.

Configuration
REQ-026 With macro COUNT_MONITOR_ERR_EN defined, output err (1 bit, sticky) SHALL set on any non-S_INIT publish whose new value != (old value-1) mod 32, and SHALL clear only by clear.
REQ-027 Without COUNT_MONITOR_ERR_EN, port err and its logic SHALL be absent; all other behaviour is identical.

Verification
REQ-028 clear=1 for 2 cycles, then cnt_in=5'd7, enable=1 held -> valid single pulse after 4th edge; value=7, zero=0, wrap=0.
REQ-029 Down-count 2,1,0,31, each held 6 cycles -> four valid pulses; wrap pulses only with 31; wrap_count=1; zero=1 only while value=0.
REQ-030 Stable 10, then a 1-cycle glitch to 13, then back to 10 -> no valid pulse; value stays 10; state returns to S_STABLE.
REQ-031 300 sequences of 0->31 with STABLE_CYCLES=2 -> wrap_count=255, wrap keeps pulsing, no rollover.
REQ-032 enable=0 while cnt_in changes 20->19 -> value holds 20; enable=1 -> value=19 after 2 edges, valid pulse; clear mid-settle -> all outputs 0 next edge.
REQ-033 With COUNT_MONITOR_ERR_EN: publish 9 then 6 -> err=1 and stays 1; publish 9 then 8 -> err remains 0.
